radix4_seq_mult: RTL and testbench
==================================

Name: radix4_seq_mult

Overview:
- Sequential unsigned radix-4 multiplier; sits directly downstream of the multiples-generation stage, which produces A, 2A, 3A and 4A.
- Consumes precomputed A, 2A, 3A plus multiplier operand B.
- Retires one 2-bit digit of B per cycle by selecting 0/A/2A/3A and accumulating it at weight 4^k.
- Presents the full product over a valid/ready handshake.

Parameters:
- SIZE, 18, width of each multiple input; operand A width is SIZE-2 (so 4A fits); legal SIZE >= 3.
- B_WIDTH, 16, multiplier operand width; must be even and >= 2; N = B_WIDTH/2 digits.
- P_WIDTH, derived = SIZE-2+B_WIDTH, product width (localparam, not overridable).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- in_valid_i  in  1  operands valid.
- in_ready_o  out  1  block can accept operands.
- mult_a_i  in  SIZE  +A from upstream (its out_0).
- mult_2a_i  in  SIZE  +2A (upstream out_1).
- mult_3a_i  in  SIZE  +3A (upstream out_2); upstream 4A is not consumed.
- b_i  in  B_WIDTH  multiplier operand, unsigned.
- out_valid_o  out  1  product valid.
- out_ready_i  in  1  consumer accepts product.
- product_o  out  P_WIDTH  A*B, unsigned.
- busy_o  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_i high at an edge): state=IDLE, acc=0, digit counter=0, captured regs=0.
  - Outputs after reset: in_ready_o=1, out_valid_o=0, product_o=0, busy_o=0.
  - Reset wins over every other event. Reset mid-operation discards the in-flight product; no out_valid pulse follows.
- States:
  - IDLE: in_ready_o=1.
    - On in_valid_i && in_ready_o: capture mult_a/2a/3a and b_i; acc<=0; cnt<=0; go RUN.
  - RUN: in_ready_o=0.
    - Each cycle: d = b_reg[2*cnt+1:2*cnt]; sel = 0/A/2A/3A for d = 0/1/2/3.
    - acc <= acc + (sel << 2*cnt), truncated to P_WIDTH (never overflows for legal operands); cnt <= cnt+1.
    - When cnt == N-1, the accumulation completes and the state goes to DONE.
  - DONE: out_valid_o=1; product_o=acc, held stable until accepted.
    - On out_ready_i: go IDLE.
- Latency: out_valid_o rises exactly N cycles after the acceptance edge (default 8).
  - Throughput: one product per N+2 cycles minimum.
  - No same-cycle accept-while-done; in_ready_o rises the cycle after output handshake.
- Inputs:
  - Multiples and b_i are sampled only at the acceptance edge; changes during RUN/DONE are ignored.
  - in_valid_i while busy is ignored (not queued).
- product_o:
  - Reflects acc in all states but is meaningful only when out_valid_o=1.
  - Cleared to 0 at operand acceptance.
- Counter width: $clog2(N), minimum 1 bit.
- Multiples are trusted consistent (2A, 3A correct); no internal check.

Optional Feature:
- ZERO_SKIP_EN:
  - Defined: in RUN, if all remaining digits b_reg[B_WIDTH-1:2*(cnt+1)] are zero after the current accumulation, go DONE immediately.
    - Latency = max(1, index of highest nonzero digit + 1) cycles.
    - Operand b_i=0 gives latency 1, product 0.
  - Undefined: fixed N-cycle latency, no skip logic synthesised.
  - Product value identical in both builds.

Test Plan:
- Reset then A=3 (mult 3/6/9), B=5, out_ready_i=1:
  - product_o=15; out_valid_o high 8 cycles after accept (undefined macro).
  - Macro defined: high after 2 cycles.
- A=0xFFFF (mult 0xFFFF/0x1FFFE/0x2FFFD), B=0xFFFF -> product_o=0xFFFE0001, latency 8 in both builds.
- A=0x1234, B=0 -> product 0; latency 8 (no macro) / 1 (macro). Then A=0, B=0xABCD -> product 0.
- Backpressure: out_ready_i=0 for 5 cycles after out_valid_o.
  - product_o and out_valid_o stay stable; in_ready_o=0; in_valid_i with new operands ignored.
  - Release -> IDLE next cycle; next op uses only newly presented operands.
- Operand change mid-RUN: change b_i/multiples 2 cycles after accept -> product still matches the captured operands.
- rst_i asserted at cycle 4 of RUN:
  - Next cycle in_ready_o=1, out_valid_o=0, product_o=0.
  - No stale result appears; the following op (A=7, B=9) yields 63.

Source files
------------

// File: rtl/radix4_seq_mult.sv
// rtl/radix4_seq_mult.sv - sequential unsigned radix-4 multiplier over precomputed multiples
//
// Retires one 2-bit digit of B per cycle by adding 0/A/2A/3A, shifted to weight 4^k,
// into an accumulator. The product is then presented over a valid/ready handshake.
//
// Optional macro ZERO_SKIP_EN: when it is defined, RUN ends early once every digit
// above the current one is zero. The product is the same in both builds.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands (IDLE)
//   mult_a_i     +A  (SIZE bits, A itself is SIZE-2 bits)
//   mult_2a_i    +2A
//   mult_3a_i    +3A
//   b_i          multiplier operand, unsigned, B_WIDTH bits
//   out_valid_o  product valid (DONE)
//   out_ready_i  consumer accepts product
//   product_o    accumulator, P_WIDTH = SIZE-2+B_WIDTH bits
//   busy_o       high in RUN or DONE
module radix4_seq_mult #(
  parameter int SIZE    = 18,
  parameter int B_WIDTH = 16,
  localparam int P_WIDTH = SIZE - 2 + B_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [SIZE-1:0]    mult_a_i,
  input  logic [SIZE-1:0]    mult_2a_i,
  input  logic [SIZE-1:0]    mult_3a_i,
  input  logic [B_WIDTH-1:0] b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [P_WIDTH-1:0] product_o,
  output logic               busy_o
);

  localparam int N     = B_WIDTH / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0]    a_q, a_d;
  logic [SIZE-1:0]    a2_q, a2_d;
  logic [SIZE-1:0]    a3_q, a3_d;
  logic [B_WIDTH-1:0] b_q, b_d;

  // Bit offset of the current digit: 2*cnt.
  logic [CNT_W:0]     shift_amt;
  logic [1:0]         digit;
  logic [SIZE-1:0]    sel;
  logic               last_digit;

  assign shift_amt = {cnt_q, 1'b0};
  assign digit     = 2'(b_q >> shift_amt);

  always_comb begin
    sel = '0;
    case (digit)
      2'd1:    sel = a_q;
      2'd2:    sel = a2_q;
      2'd3:    sel = a3_q;
      default: sel = '0;
    endcase
  end

`ifdef ZERO_SKIP_EN
  // Offset of the digit just above the current one. One extra bit is needed
  // because this offset reaches B_WIDTH on the final digit.
  logic [CNT_W+1:0] next_shift;
  assign next_shift = {1'b0, shift_amt} + (CNT_W + 2)'(2);
  assign last_digit = (cnt_q == CNT_W'(N - 1)) || ((b_q >> next_shift) == '0);
`else
  assign last_digit = (cnt_q == CNT_W'(N - 1));
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    a2_d        = a2_q;
    a3_d        = a3_q;
    b_d         = b_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_d     = mult_a_i;
          a2_d    = mult_2a_i;
          a3_d    = mult_3a_i;
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        acc_d  = acc_q + (P_WIDTH'(sel) << shift_amt);
        cnt_d  = cnt_q + 1'b1;
        if (last_digit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      a2_q    <= a2_d;
      a3_q    <= a3_d;
      b_q     <= b_d;
    end
  end

  assign product_o = acc_q;

endmodule

// File: tb/tb_radix4_seq_mult.sv
// tb/tb_radix4_seq_mult.sv - self-checking bench for radix4_seq_mult
module tb_radix4_seq_mult;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] m_a, m_2a, m_3a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  radix4_seq_mult #(.SIZE(18), .B_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mult_a_i    (m_a),
    .mult_2a_i   (m_2a),
    .mult_3a_i   (m_3a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .product_o   (product),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] bv);
`ifdef ZERO_SKIP_EN
    int hi = 0;
    for (int k = 0; k < 8; k++) if (bv[2*k +: 2] != 2'b00) hi = k;
    return hi + 1;
`else
    return 8;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] bv);
    m_a  = {2'b00, a};
    m_2a = {1'b0, a, 1'b0};
    m_3a = {2'b00, a} + {1'b0, a, 1'b0};
    b    = bv;
  endtask

  // Present operands in IDLE, then count cycles from the acceptance edge until
  // out_valid. A missing result is reported as latency -1.
  task automatic start_op(input logic [15:0] a, input logic [15:0] bv);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      cyc();
      guard++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    set_ops(a, bv);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("busy_after_accept", {62'd0, busy, in_ready}, 64'b10);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat <= 30) begin
      cyc();
      if (!out_valid) lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] bv, output int lat,
                        output logic [31:0] prod);
    start_op(a, bv);
    lat = 0;
    while (!out_valid && lat <= 30) begin
      cyc();
      lat++;
    end
    if (!out_valid) lat = -1;
    prod = product;
    cyc();
  endtask

  initial begin
    int          lat;
    logic [31:0] prod;
    logic        stable;

    vecs[0] = '{16'd3,      16'd5,      32'd15};
    vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001};
    vecs[2] = '{16'h1234,   16'h0000,   32'd0};
    vecs[3] = '{16'h0000,   16'hABCD,   32'd0};
    vecs[4] = '{16'd7,      16'd9,      32'd63};
    vecs[5] = '{16'h8000,   16'h4000,   32'h20000000};
    vecs[6] = '{16'd1,      16'hC000,   32'h0000C000};
    vecs[7] = '{16'h00FF,   16'h0101,   32'h0000FFFF};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_ops(16'd0, 16'd0);
    cyc();
    cyc();
    rst = 1'b0;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product",   64'(product),   64'd0);
    check("reset_busy",      64'(busy),      64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, prod);
      check($sformatf("vec%0d_product", i), 64'(prod), 64'(vecs[i].p));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].b)));
      check($sformatf("vec%0d_idle_after", i), 64'(in_ready), 64'd1);
    end

    // Backpressure: the result holds while new operands are offered and ignored.
    out_ready = 1'b0;
    start_op(16'd5, 16'd6);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'(exp_lat(16'd6)));
    set_ops(16'd9, 16'd9);
    in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(out_valid && product == 32'd30 && !in_ready && busy)) stable = 1'b0;
      cyc();
    end
    check("bp_hold_stable", 64'(stable), 64'd1);
    check("bp_product", 64'(product), 64'd30);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("bp_release_idle", {62'd0, in_ready, out_valid}, 64'b10);
    run_op(16'd2, 16'd3, lat, prod);
    check("bp_next_product", 64'(prod), 64'd6);

    // Operand change mid-RUN must not affect the captured operands.
    start_op(16'd11, 16'd13);
    cyc();
    set_ops(16'hFFFF, 16'hFFFF);
    wait_valid(lat);
    check("midrun_product", 64'(product), 64'd143);
    cyc();
    set_ops(16'd0, 16'd0);

    // Reset on the fourth RUN cycle drops the operation.
    start_op(16'd100, 16'hFFFF);
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_state", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("midrst_product", 64'(product), 64'd0);
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) stable = 1'b0;
      cyc();
    end
    check("midrst_no_stale", 64'(stable), 64'd1);
    run_op(16'd7, 16'd9, lat, prod);
    check("post_rst_product", 64'(prod), 64'd63);
    check("post_rst_latency", 64'(lat), 64'(exp_lat(16'd9)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
